// File: rtl/hazard_controller_if.sv
// ============================================================================
//  Module   : hazard_controller_if
//  Purpose  : ID-stage/branch inputs and pipeline control outputs exchanged
//             between the MIPS datapath and the hazard controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       id_dest;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             branch_taken_mem;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             id_bypass_a;
    logic             id_bypass_b;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, branch_taken_mem,
        input  pc_write, ifid_write, idex_bubble, flush, fwd_a, fwd_b,
               id_bypass_a, id_bypass_b, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, branch_taken_mem,
        output pc_write, ifid_write, idex_bubble, flush, fwd_a, fwd_b,
               id_bypass_a, id_bypass_b, stall_count, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
//  Module   : hazard_controller
//  Purpose  : Five-stage MIPS stall/flush/forwarding controller driven from a
//             registered shadow of the EX, MEM and WB instructions.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_controller_if.slave hz
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
    } shadow_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [1:0]       c_fwd_rf  = 2'b00;
    localparam logic [1:0]       c_fwd_mem = 2'b01;
    localparam logic [1:0]       c_fwd_wb  = 2'b10;

    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    shadow_t          w_id_entry;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_load_use;
    logic             w_stall;
    logic             w_flush;
    logic             w_unused;

    // Register 0 is hardwired, so a zero destination never produces a hit.
    function automatic logic f_writes(input shadow_t s, input logic [4:0] src);
        return s.valid && s.reg_write && (s.dest != 5'd0) && (s.dest == src);
    endfunction

    function automatic logic [1:0] f_fwd_sel(input logic uses, input logic [4:0] src,
                                             input shadow_t ex, input shadow_t mem,
                                             input shadow_t wb);
        logic [1:0] sel;
        sel = c_fwd_rf;
        if (ex.valid && uses) begin
            if (f_writes(mem, src))
                sel = c_fwd_mem;
            else if (f_writes(wb, src))
                sel = c_fwd_wb;
        end
        return sel;
    endfunction

    always_comb begin
        w_id_entry           = '0;
        w_id_entry.valid     = 1'b1;
        w_id_entry.reg_write = hz.id_reg_write;
        w_id_entry.mem_read  = hz.id_mem_read;
        w_id_entry.dest      = hz.id_dest;
        w_id_entry.rs        = hz.id_rs;
        w_id_entry.rt        = hz.id_rt;
        w_id_entry.uses_rs   = hz.id_uses_rs;
        w_id_entry.uses_rt   = hz.id_uses_rt;
    end

    assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.dest != 5'd0) &&
                        ((hz.id_uses_rs && (hz.id_rs == r_ex.dest)) ||
                         (hz.id_uses_rt && (hz.id_rt == r_ex.dest)));
    assign w_flush    = hz.branch_taken_mem;
    // A taken branch squashes the consumer anyway, so the stall is dropped.
    assign w_stall    = w_load_use && !w_flush;

    assign hz.pc_write    = !w_stall;
    assign hz.ifid_write  = !w_stall;
    assign hz.idex_bubble = w_stall;
    assign hz.flush       = w_flush;
    assign hz.fwd_a       = f_fwd_sel(r_ex.uses_rs, r_ex.rs, r_ex, r_mem, r_wb);
    assign hz.fwd_b       = f_fwd_sel(r_ex.uses_rt, r_ex.rt, r_ex, r_mem, r_wb);
    assign hz.id_bypass_a = hz.id_uses_rs && f_writes(r_wb, hz.id_rs);
    assign hz.id_bypass_b = hz.id_uses_rt && f_writes(r_wb, hz.id_rt);
    assign hz.stall_count = r_stall_count;
    assign hz.flush_count = r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (w_flush) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= r_mem;
        end else if (w_stall) begin
            r_ex  <= '0;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end else begin
            r_ex  <= w_id_entry;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != c_cnt_max))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_flush && (r_flush_count != c_cnt_max))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    // WB only ever supplies a destination; its source fields are dead.
    assign w_unused = ^{r_wb.mem_read, r_wb.rs, r_wb.rt, r_wb.uses_rs, r_wb.uses_rt};

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
//  Module   : tb_hazard_controller
//  Purpose  : Directed self-checking bench for hazard_controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

    localparam int c_cnt_w = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hazard_controller_if #(.CNT_W(c_cnt_w)) bus ();

    hazard_controller #(.CNT_W(c_cnt_w)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic [4:0] dest,
                            input logic rw, input logic mr, input logic br);
        bus.id_rs            = rs;
        bus.id_rt            = rt;
        bus.id_uses_rs       = urs;
        bus.id_uses_rt       = urt;
        bus.id_dest          = dest;
        bus.id_reg_write     = rw;
        bus.id_mem_read      = mr;
        bus.branch_taken_mem = br;
        #1;
    endtask

    task automatic drive_idle();
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %b want 1", bus.pc_write); end
        checks++; if (bus.ifid_write !== 1'b1) begin errors++; $display("FAIL reset_ifid_write: got %b want 1", bus.ifid_write); end
        checks++; if (bus.idex_bubble !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL reset_bubble_flush: got %b%b want 00", bus.idex_bubble, bus.flush); end
        checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); end
        checks++; if (bus.id_bypass_a !== 1'b0 || bus.id_bypass_b !== 1'b0) begin errors++; $display("FAIL reset_bypass: got %b%b want 00", bus.id_bypass_a, bus.id_bypass_b); end
        checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.stall_count, bus.flush_count); end
    endtask

    task automatic test_alu_chain();
        do_reset();
        drive_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add $3,$1,$2
        tick();
        drive_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // sub $4,$3,$5
        checks++; if (bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %b want 0", bus.idex_bubble); end
        tick();
        drive_id(5'd3, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // and $10,$3,$9
        checks++; if (bus.fwd_a !== 2'b01 || bus.fwd_b !== 2'b00) begin errors++; $display("FAIL alu_fwd_mem: got %b/%b want 01/00", bus.fwd_a, bus.fwd_b); end
        checks++; if (bus.id_bypass_a !== 1'b0) begin errors++; $display("FAIL alu_no_bypass: got %b want 0", bus.id_bypass_a); end
        tick();
        drive_idle();
        checks++; if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b00) begin errors++; $display("FAIL alu_fwd_wb: got %b/%b want 10/00", bus.fwd_a, bus.fwd_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(5'd0, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);   // lw $8,0($0)
        tick();
        drive_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // add $9,$8,$8
        checks++; if ({bus.pc_write, bus.ifid_write, bus.idex_bubble} !== 3'b001) begin errors++; $display("FAIL lu_stall: got %b want 001", {bus.pc_write, bus.ifid_write, bus.idex_bubble}); end
        tick();
        checks++; if ({bus.pc_write, bus.ifid_write, bus.idex_bubble} !== 3'b110) begin errors++; $display("FAIL lu_one_cycle: got %b want 110", {bus.pc_write, bus.ifid_write, bus.idex_bubble}); end
        checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_stall_count: got %0d want 1", bus.stall_count); end
        tick();
        drive_idle();
        checks++; if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b10) begin errors++; $display("FAIL lu_fwd_wb: got %b/%b want 10/10", bus.fwd_a, bus.fwd_b); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        drive_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw $0
        tick();
        drive_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);   // add $1,$0,$0
        checks++; if (bus.idex_bubble !== 1'b0 || bus.pc_write !== 1'b1) begin errors++; $display("FAIL r0_no_stall: got bubble=%b pc=%b want 0/1", bus.idex_bubble, bus.pc_write); end
        tick();
        drive_idle();
        checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin errors++; $display("FAIL r0_fwd_ex: got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); end
        checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL r0_stall_count: got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_branch_vs_stall();
        do_reset();
        drive_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // add $7,$1,$2
        tick();
        drive_id(5'd0, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);   // lw $8
        tick();
        drive_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);   // add $9 with taken branch
        checks++; if ({bus.flush, bus.pc_write, bus.ifid_write, bus.idex_bubble} !== 4'b1110) begin errors++; $display("FAIL br_priority: got %b want 1110", {bus.flush, bus.pc_write, bus.ifid_write, bus.idex_bubble}); end
        tick();
        drive_id(5'd2, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);  // reads $7 as rt
        checks++; if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'd0) begin errors++; $display("FAIL br_counts: got %0d/%0d want 1/0", bus.flush_count, bus.stall_count); end
        checks++; if (bus.flush !== 1'b0 || bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL br_cleared: got %b%b want 00", bus.flush, bus.idex_bubble); end
        checks++; if (bus.id_bypass_b !== 1'b1 || bus.id_bypass_a !== 1'b0) begin errors++; $display("FAIL br_wb_keeps_mem: got a=%b b=%b want 0/1", bus.id_bypass_a, bus.id_bypass_b); end
    endtask

    task automatic test_wb_bypass();
        do_reset();
        drive_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);   // addi $7,$1,imm
        tick();
        drive_idle();
        tick();
        tick();
        drive_id(5'd2, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.id_bypass_b !== 1'b1 || bus.id_bypass_a !== 1'b0) begin errors++; $display("FAIL wb_bypass: got a=%b b=%b want 0/1", bus.id_bypass_a, bus.id_bypass_b); end
        drive_id(5'd7, 5'd7, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.id_bypass_b !== 1'b0 || bus.id_bypass_a !== 1'b0) begin errors++; $display("FAIL wb_bypass_unused: got a=%b b=%b want 0/0", bus.id_bypass_a, bus.id_bypass_b); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive_id(5'd0, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({bus.pc_write, bus.idex_bubble} !== 2'b10 || bus.stall_count !== 4'd0) begin errors++; $display("FAIL rst_mid_stall: got pc=%b bubble=%b cnt=%0d want 1/0/0", bus.pc_write, bus.idex_bubble, bus.stall_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_id(5'd0, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
            tick();
            drive_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            if (i == 14) begin
                checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d want 15", bus.stall_count); end
            end
        end
        checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_stall_hold: got %0d want 15", bus.stall_count); end
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) tick();
        checks++; if (bus.flush_count !== 4'd15) begin errors++; $display("FAIL sat_flush_hold: got %0d want 15", bus.flush_count); end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_reg_zero();
        test_branch_vs_stall();
        test_wb_bypass();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage MIPS datapath (IF, ID, EX, MEM, WB). It keeps a registered shadow of the destination and control information of every in-flight instruction. From that shadow it drives the stall, bubble and flush controls, the ALU-operand forwarding selects and the ID-stage register-file bypass. It also keeps saturating stall and flush counters that the display path reads for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_dest  in  5  destination register after the RegDst selection for the ID instruction
- id_reg_write  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- branch_taken_mem  in  1  branch in MEM resolved taken this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID register load enable
- idex_bubble  out  1  load a NOP (all control bits 0) into ID/EX
- flush  out  1  clear IF/ID, ID/EX and EX/MEM at the next edge
- fwd_a  out  2  EX operand A select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data
- fwd_b  out  2  EX operand B select, same encoding as fwd_a
- id_bypass_a  out  1  ID reads WriteData instead of ReadData1
- id_bypass_b  out  1  ID reads WriteData instead of ReadData2
- stall_count  out  CNT_W  load-use stall cycles, saturating
- flush_count  out  CNT_W  taken-branch flushes, saturating

## Operation
- Shadow stages EX, MEM and WB. Each holds {valid, reg_write, mem_read, dest, rs, rt, uses_rs, uses_rt}.
- Register 0 is never a hazard source. Any compare whose dest is 0 is false.
- Load-use hazard (stall) is asserted when all of the following hold:
  - EX.valid and EX.mem_read
  - EX.dest != 0
  - (id_uses_rs and id_rs == EX.dest) or (id_uses_rt and id_rt == EX.dest)
- Stall response: pc_write = 0, ifid_write = 0, idex_bubble = 1. The shadow EX loads valid = 0 and MEM advances normally.
- Taken branch (branch_taken_mem = 1):
  - flush = 1 and pc_write = 1.
  - At the next edge, shadow EX and MEM load valid = 0 and WB loads the old MEM entry.
  - Flush has priority over stall: when both occur, stall outputs are deasserted and stall_count does not increment.
- Normal advance: EX takes the ID information, MEM takes EX, WB takes MEM.
- Forwarding for operand A (fwd_a), evaluated on the EX shadow's rs:
  - 01 if MEM.valid, MEM.reg_write, MEM.dest != 0 and MEM.dest == EX.rs.
  - Otherwise 10 if the same conditions hold against WB.
  - Otherwise 00.
  - If EX.valid = 0 or EX.uses_rs = 0, fwd_a = 00.
- fwd_b follows the same rules using EX.rt and EX.uses_rt.
- ID bypass: id_bypass_a = WB.valid, WB.reg_write, WB.dest != 0, id_uses_rs and id_rs == WB.dest. id_bypass_b is the same with rt.
- Counters saturate at 2^CNT_W - 1.
  - stall_count increments on each edge where a stall is asserted.
  - flush_count increments on each edge where flush is asserted.

## Timing
- All control and forwarding outputs are combinational from the shadow state plus the current ID and branch inputs. They are valid in the same cycle.
- Shadow stages and counters update only on the rising edge of clk.
- Reset is synchronous: on an edge with rst = 1, all shadow valid bits are cleared and both counters are set to 0.
- Values after reset, with idle inputs:
  - pc_write = 1, ifid_write = 1
  - idex_bubble = 0, flush = 0
  - fwd_a = fwd_b = 00, id_bypass_a = id_bypass_b = 0
  - stall_count = flush_count = 0
- Reset asserted mid-stall or mid-flush overrides both; the next cycle shows the reset output values.
- A load-use stall lasts exactly 1 cycle. After it, the load is in MEM, the shadow EX is a bubble, and the consumer is forwarded from WB next cycle (fwd = 10).
- Flush latency: branch_taken_mem in cycle t produces three bubble slots (IF/ID, ID/EX, EX/MEM) at the edge ending cycle t.
- EX/MEM forwarding of a load result never occurs, because the stall guarantees a one-instruction gap.

## Test plan
- Reset check: hold rst for 2 cycles, release with idle inputs -> pc_write = 1, ifid_write = 1, all selects 00, both counters 0.
- ALU chain: add $3,$1,$2 followed by sub $4,$3,$5 -> with sub in EX, fwd_a = 01; a third instruction using $3 two slots later -> fwd = 10.
- Load-use: lw $8,0($0) followed by add $9,$8,$8:
  - Expect 1 cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - Next cycle: fwd_a = fwd_b = 10 for the add.
  - stall_count = 1.
- Register 0: lw $0 then add $1,$0,$0 -> no stall and fwd = 00 throughout.
- Branch vs stall: branch_taken_mem = 1 in the same cycle as a load-use condition -> flush = 1, pc_write = 1, stall outputs deasserted, flush_count += 1, stall_count unchanged.
- Saturation: CNT_W = 4, 20 consecutive load-use pairs -> stall_count holds at 15.
- WB bypass: an instruction in WB writes $7 while ID reads $7 as rt -> id_bypass_b = 1 and id_bypass_a = 0.
